mont_final_reduce: RTL

- Downstream stage of the radix-4 Montgomery multiplier. Takes its unreduced product C, where 0 <= C < 2M, together with modulus M.
- Returns C mod M as a 1025-bit value, using one conditional subtraction.
- The subtraction runs word-serially, WORD bits per cycle, to keep the carry chain short at the same clock as the multiplier's adder.
- Sits between the multiplier's result/done outputs and the exponentiation/top-level controller.

---
 rtl/mont_final_reduce_pkg.sv | 16 +
 rtl/mont_final_reduce_word_sub.sv | 17 +
 rtl/mont_final_reduce.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mont_final_reduce_pkg.sv
// Shared widths and FSM encoding for the Montgomery multiplier, final reduction and controller.
package mont_final_reduce_pkg;

  localparam int unsigned C_WIDTH   = 1028;
  localparam int unsigned M_WIDTH   = 1024;
  localparam int unsigned R_WIDTH   = 1025;
  localparam int unsigned PAD_WIDTH = 1152;

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StSel,
    StDone
  } mfr_state_e;

endpackage

// File: rtl/mont_final_reduce_word_sub.sv
// One slice of the word-serial subtractor: {bout, diff} = a - b - bin.
module mont_final_reduce_word_sub #(
  parameter int unsigned WORD = 128
) (
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic            bin,
  output logic [WORD-1:0] diff,
  output logic            bout
);

  // One extra bit on the left catches the borrow out of the slice.
  always_comb begin
    {bout, diff} = {1'b0, a} - {1'b0, b} - {{WORD{1'b0}}, bin};
  end

endmodule

// File: rtl/mont_final_reduce.sv
// Final Montgomery reduction: C mod M for 0 <= C < 2M via one word-serial conditional subtraction.
module mont_final_reduce
  import mont_final_reduce_pkg::*;
#(
  parameter int unsigned WORD = 128
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [C_WIDTH-1:0] in_c,
  input  logic [M_WIDTH-1:0] in_m,
  output logic               busy,
  output logic               done,
  output logic [R_WIDTH-1:0] result,
  output logic               range_err
);

  localparam int unsigned NWORDS = PAD_WIDTH / WORD;
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  mfr_state_e             state_q, state_d;
  logic [PAD_WIDTH-1:0]   c_sr_q, c_sr_d;
  logic [PAD_WIDTH-1:0]   m_sr_q, m_sr_d;
  logic [PAD_WIDTH-1:0]   d_sr_q, d_sr_d;
  logic [R_WIDTH-1:0]     c_keep_q, c_keep_d;
  logic                   borrow_q, borrow_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic [R_WIDTH-1:0]     result_q, result_d;
  logic                   range_err_q, range_err_d;

  logic [WORD-1:0]        slice_diff;
  logic                   slice_bout;

  mont_final_reduce_word_sub #(
    .WORD (WORD)
  ) u_word_sub (
    .a    (c_sr_q[WORD-1:0]),
    .b    (m_sr_q[WORD-1:0]),
    .bin  (borrow_q),
    .diff (slice_diff),
    .bout (slice_bout)
  );

  always_comb begin
    state_d     = state_q;
    c_sr_d      = c_sr_q;
    m_sr_d      = m_sr_q;
    d_sr_d      = d_sr_q;
    c_keep_d    = c_keep_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    result_d    = result_q;
    range_err_d = range_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          c_sr_d   = PAD_WIDTH'(in_c);
          m_sr_d   = PAD_WIDTH'(in_m);
          c_keep_d = in_c[R_WIDTH-1:0];
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StSub;
        end
      end
      StSub: begin
        // LSW first: each difference slice enters at the top so D ends up LSW-aligned.
        d_sr_d   = {slice_diff, d_sr_q[PAD_WIDTH-1:WORD]};
        c_sr_d   = c_sr_q >> WORD;
        m_sr_d   = m_sr_q >> WORD;
        borrow_d = slice_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NWORDS - 1)) begin
          state_d = StSel;
        end
      end
      StSel: begin
        if (borrow_q) begin
          result_d    = c_keep_q;
          range_err_d = 1'b0;
        end else begin
          result_d    = d_sr_q[R_WIDTH-1:0];
          range_err_d = |d_sr_q[PAD_WIDTH-1:R_WIDTH];
        end
        busy_d  = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      c_sr_q      <= '0;
      m_sr_q      <= '0;
      d_sr_q      <= '0;
      c_keep_q    <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_sr_q      <= c_sr_d;
      m_sr_q      <= m_sr_d;
      d_sr_q      <= d_sr_d;
      c_keep_q    <= c_keep_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      range_err_q <= range_err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign range_err = range_err_q;

endmodule
